// File: rtl/imu_pkg.sv
// rtl/imu_pkg.sv - shared byte map, defaults and state type for the IMU sample assembler
package imu_pkg;

   localparam int BYTE_AXH = 0;
   localparam int BYTE_AXL = 1;
   localparam int BYTE_AYH = 2;
   localparam int BYTE_AYL = 3;
   localparam int BYTE_AZH = 4;
   localparam int BYTE_AZL = 5;
   localparam int BYTE_TH  = 6;
   localparam int BYTE_TL  = 7;

   localparam int Z_ONE_G_DEFAULT = 16384;

   typedef enum logic {
      CAL,
      RUN
   } cal_state_t;

   // Clamp a widened average into the 16-bit bias range (a Z bias can exceed it).
   function automatic logic signed [15:0] sat16(input logic signed [23:0] v);
      if (v > 24'sd32767) begin
         return 16'sh7FFF;
      end else if (v < -24'sd32768) begin
         return 16'sh8000;
      end else begin
         return v[15:0];
      end
   endfunction

endpackage

// File: rtl/sat_sub16.sv
// rtl/sat_sub16.sv - signed 16-bit a - b with 17-bit intermediate, clamped to [-32768, 32767]
module sat_sub16 (
   input  logic signed [15:0] a,
   input  logic signed [15:0] b,
   output logic signed [15:0] y
);

   logic [16:0] diff;

   assign diff = {a[15], a} - {b[15], b};

   // Overflow shows up as disagreement between the two top bits of the 17-bit result.
   always_comb begin
      y = diff[15:0];
      if (diff[16] != diff[15]) begin
         y = diff[16] ? 16'sh8000 : 16'sh7FFF;
      end
   end

endmodule

// File: rtl/imu_sample_assembler.sv
// rtl/imu_sample_assembler.sv - turns I2C read frames into accel/temp samples
// Bias calibration (CAL/RUN) is present only when IMU_BIAS_CAL_EN is defined.
module imu_sample_assembler
   import imu_pkg::*;
#(
   parameter int CAL_SHIFT = 4,
   parameter int Z_ONE_G   = Z_ONE_G_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  end_flag,
   input  logic [7:0][7:0]       received_data,
   input  logic                  recal,
   output logic signed [15:0]    accel_x,
   output logic signed [15:0]    accel_y,
   output logic signed [15:0]    accel_z,
   output logic signed [15:0]    temp_raw,
   output logic                  sample_valid,
   output logic                  cal_done
);

   logic                end_q;
   logic                rise;
   logic                drop;
   logic                raw_valid;
   logic signed [15:0]  raw_x, raw_y, raw_z, raw_t;
   logic signed [15:0]  sub_b_x, sub_b_y, sub_b_z;
   logic signed [15:0]  corr_x, corr_y, corr_z;

   assign rise = end_flag & ~end_q;

   // History resets high so a read-complete level already present is not taken as a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         end_q     <= 1'b1;
         raw_valid <= 1'b0;
         raw_x     <= '0;
         raw_y     <= '0;
         raw_z     <= '0;
         raw_t     <= '0;
      end else begin
         end_q     <= end_flag;
         raw_valid <= rise & ~drop;
         if (rise) begin
            raw_x <= {received_data[BYTE_AXH], received_data[BYTE_AXL]};
            raw_y <= {received_data[BYTE_AYH], received_data[BYTE_AYL]};
            raw_z <= {received_data[BYTE_AZH], received_data[BYTE_AZL]};
            raw_t <= {received_data[BYTE_TH],  received_data[BYTE_TL]};
         end
      end
   end

   sat_sub16 u_sub_x (.a(raw_x), .b(sub_b_x), .y(corr_x));
   sat_sub16 u_sub_y (.a(raw_y), .b(sub_b_y), .y(corr_y));
   sat_sub16 u_sub_z (.a(raw_z), .b(sub_b_z), .y(corr_z));

`ifdef IMU_BIAS_CAL_EN

   localparam int ACC_W = 16 + CAL_SHIFT + 1;
   localparam int CNT_W = CAL_SHIFT + 1;
   localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'((1 << CAL_SHIFT) - 1);

   cal_state_t                 state;
   logic [CNT_W-1:0]           frame_cnt;
   logic signed [ACC_W-1:0]    acc_x, acc_y, acc_z;
   logic signed [ACC_W-1:0]    sum_x, sum_y, sum_z;
   logic signed [ACC_W-1:0]    avg_x, avg_y, avg_z;
   logic signed [16:0]         z_off;
   logic signed [15:0]         bias_x, bias_y, bias_z;

   assign drop  = recal;
   assign z_off = {raw_z[15], raw_z} - 17'(Z_ONE_G);
   assign sum_x = acc_x + {{(ACC_W-16){raw_x[15]}}, raw_x};
   assign sum_y = acc_y + {{(ACC_W-16){raw_y[15]}}, raw_y};
   assign sum_z = acc_z + {{(ACC_W-17){z_off[16]}}, z_off};
   assign avg_x = sum_x >>> CAL_SHIFT;
   assign avg_y = sum_y >>> CAL_SHIFT;
   assign avg_z = sum_z >>> CAL_SHIFT;

   assign sub_b_x = bias_x;
   assign sub_b_y = bias_y;
   assign sub_b_z = bias_z;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= CAL;
         frame_cnt    <= '0;
         acc_x        <= '0;
         acc_y        <= '0;
         acc_z        <= '0;
         bias_x       <= '0;
         bias_y       <= '0;
         bias_z       <= '0;
         cal_done     <= 1'b0;
         sample_valid <= 1'b0;
         accel_x      <= '0;
         accel_y      <= '0;
         accel_z      <= '0;
         temp_raw     <= '0;
      end else begin
         sample_valid <= 1'b0;
         // recal also discards a frame already waiting in stage 2
         if (recal) begin
            state     <= CAL;
            frame_cnt <= '0;
            acc_x     <= '0;
            acc_y     <= '0;
            acc_z     <= '0;
            cal_done  <= 1'b0;
         end else if (raw_valid) begin
            case (state)
               CAL: begin
                  acc_x     <= sum_x;
                  acc_y     <= sum_y;
                  acc_z     <= sum_z;
                  frame_cnt <= frame_cnt + CNT_W'(1);
                  if (frame_cnt == LAST_FRAME) begin
                     bias_x   <= sat16({{(24-ACC_W){avg_x[ACC_W-1]}}, avg_x});
                     bias_y   <= sat16({{(24-ACC_W){avg_y[ACC_W-1]}}, avg_y});
                     bias_z   <= sat16({{(24-ACC_W){avg_z[ACC_W-1]}}, avg_z});
                     cal_done <= 1'b1;
                     state    <= RUN;
                  end
               end
               RUN: begin
                  accel_x      <= corr_x;
                  accel_y      <= corr_y;
                  accel_z      <= corr_z;
                  temp_raw     <= raw_t;
                  sample_valid <= 1'b1;
               end
               default: state <= CAL;
            endcase
         end
      end
   end

`else

   localparam int cfg_unused = CAL_SHIFT + Z_ONE_G;
   logic recal_unused;

   assign recal_unused = recal;
   assign drop         = 1'b0;
   assign sub_b_x      = '0;
   assign sub_b_y      = '0;
   assign sub_b_z      = '0;
   assign cal_done     = 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sample_valid <= 1'b0;
         accel_x      <= '0;
         accel_y      <= '0;
         accel_z      <= '0;
         temp_raw     <= '0;
      end else begin
         sample_valid <= raw_valid;
         if (raw_valid) begin
            accel_x  <= corr_x;
            accel_y  <= corr_y;
            accel_z  <= corr_z;
            temp_raw <= raw_t;
         end
      end
   end

`endif

endmodule

// File: doc/imu_sample_assembler.md
IMU_SAMPLE_ASSEMBLER -- requirements
Module: imu_sample_assembler

Interface
REQ-001 The block SHALL have parameter CAL_SHIFT, default 4, meaning calibration averages 2^CAL_SHIFT frames; legal range 1..6.
REQ-002 The block SHALL have parameter Z_ONE_G, default 16384, meaning the Z-axis 1 g count at ±2 g full scale.
REQ-003 The block SHALL have port clk, input, 1 bit: the I2C master clock domain, the same clock that drives the I2C driver.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port end_flag, input, 1 bit: the I2C driver read-complete level.
REQ-006 The block SHALL have port received_data, input, 8x8 bits: bytes 0..7 = AXH, AXL, AYH, AYL, AZH, AZL, TH, TL.
REQ-007 The block SHALL have port recal, input, 1 bit: single-cycle pulse that restarts calibration.
REQ-008 The block SHALL have ports accel_x, accel_y and accel_z, outputs, 16 bits signed each: corrected acceleration.
REQ-009 The block SHALL have port temp_raw, output, 16 bits signed: raw temperature word.
REQ-010 The block SHALL have port sample_valid, output, 1 bit: one-cycle pulse when the outputs update.
REQ-011 The block SHALL have port cal_done, output, 1 bit: high once bias values are valid.

Function
REQ-012 A frame SHALL be accepted only on a rising edge of end_flag (end_flag=1 while the registered previous value=0); a held-high end_flag SHALL yield exactly one frame.
REQ-013 Stage 1 SHALL capture received_data into raw registers on the edge that detects the rise, forming words {H,L} big-endian as signed 16-bit values.
REQ-014 Stage 2 SHALL compute corrected outputs and pulse sample_valid on the next edge; latency from the detecting edge SHALL be 2 edges, and back-to-back frames SHALL be accepted every cycle.
REQ-015 The state machine SHALL have states CAL and RUN; reset and recal SHALL both enter CAL with the accumulators and frame counter cleared and cal_done=0.
REQ-016 In CAL, each frame SHALL add raw X, Y and (Z - Z_ONE_G) to signed (16+CAL_SHIFT+1)-bit accumulators, and sample_valid SHALL remain 0.
REQ-017 After the 2^CAL_SHIFT-th frame, each bias SHALL be set to its accumulator arithmetically shifted right by CAL_SHIFT, cal_done SHALL be set to 1, and the state SHALL go to RUN on the same edge.
REQ-018 In RUN, the outputs SHALL be raw minus bias with 17-bit intermediate saturation to [-32768, 32767], and temp_raw SHALL be passed through uncorrected.
REQ-019 When recal coincides with a frame edge, recal SHALL win and that frame SHALL be discarded.
REQ-020 The frame counter SHALL NOT wrap; frames arriving in RUN SHALL NOT modify the bias.

Reset
REQ-021 On rst=1 at a clock edge, all outputs SHALL go to 0 (cal_done=0 when the macro is defined), biases SHALL go to 0, the state SHALL go to CAL, and the end_flag history SHALL go to 1 so a level already high is not counted.
REQ-022 Reset mid-pipeline SHALL cancel any pending sample_valid.

Configuration
REQ-023 Macro IMU_BIAS_CAL_EN defined SHALL give the behaviour of REQ-015..REQ-020.
REQ-024 Without IMU_BIAS_CAL_EN, the block SHALL have no accumulators, biases or state machine; cal_done SHALL be constant 1; every frame SHALL produce sample_valid with uncorrected raw outputs; and recal SHALL be ignored.

Structure
REQ-025 Shared package imu_pkg SHALL hold the byte-index constants, the Z_ONE_G default, and the state typedef (CAL, RUN).
REQ-026 The saturating subtract SHALL be sub-module sat_sub16, instantiated three times.

Verification
REQ-027 Verification SHALL cover: rst, then end_flag held high 10 cycles with one frame -> exactly one accepted frame, no sample_valid, still CAL.
REQ-028 Verification SHALL cover: 16 frames X=0x0010, Y=0xFFF0, Z=0x4010 -> cal_done=1 after the 16th; the 17th identical frame gives X=0, Y=0, Z=0x4000 after 2 edges.
REQ-029 Verification SHALL cover: after calibration with bias X=+16, frame X=0x8005 -> accel_x=0x8000 (saturated, no wrap).
REQ-030 Verification SHALL cover: recal on the same edge as a frame rise -> frame dropped, counter 0, cal_done=0.
REQ-031 Verification SHALL cover: rst asserted one cycle after a frame rise -> no sample_valid, all outputs 0.
REQ-032 Verification SHALL cover: build without IMU_BIAS_CAL_EN; frame TH/TL=0x0A/0xBC -> temp_raw=0x0ABC, sample_valid 2 edges later, cal_done=1.
